// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-port memory
// between requesters A and B over a req/ack handshake.
//
// state  | meaning
// IDLE   | no owner; sample requests and pick a winner
// ACCESS | one-cycle memory strobe with the latched command
// WAIT   | read latency countdown, data captured on the last cycle
// RESP   | one-cycle ack to the owner, bump its completion counter
module mem_rr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int LAT_W = 3;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = A, 1 = B
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
    logic                win_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        // On a tie B wins only when A was granted last.
        win_b     = req_b & (~req_a | ~last_q);

        case (state_q)
            IDLE: begin
                if (req_a | req_b) begin
                    owner_d = win_b;
                    last_d  = win_b;
                    we_d    = win_b ? we_b    : we_a;
                    addr_d  = win_b ? addr_b  : addr_a;
                    wdata_d = win_b ? wdata_b : wdata_a;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    lat_d   = LAT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    if (owner_q) rdata_b_d = mem_data_out;
                    else         rdata_a_d = mem_data_out;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (owner_q) begin
                    if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
                end else begin
                    if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign busy        = (state_q != IDLE);
    assign gnt_a       = busy & ~owner_q;
    assign gnt_b       = busy & owner_q;
    assign mem_write   = (state_q == ACCESS) & we_q;
    assign mem_read    = (state_q == ACCESS) & ~we_q;
    assign ack_a       = (state_q == RESP) & ~owner_q;
    assign ack_b       = (state_q == RESP) & owner_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign cnt_a       = cnt_a_q;
    assign cnt_b       = cnt_b_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_rr_arbiter;
    localparam int AW     = 5;
    localparam int DW     = 8;
    localparam int RD_LAT = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic          req_v [2];
    logic          we_v  [2];
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wdata_v [2];
    logic          ack_a, ack_b, gnt_a, gnt_b, busy, mem_read, mem_write;
    logic [DW-1:0] rdata_a, rdata_b, mem_data_in;
    logic [DW-1:0] mem_data_out = '0;
    logic [AW-1:0] mem_addr;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_v[0]), .we_a(we_v[0]), .addr_a(addr_v[0]), .wdata_a(wdata_v[0]),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_v[1]), .we_b(we_v[1]), .addr_b(addr_v[1]), .wdata_b(wdata_v[1]),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // agent configuration
    int            prob [2];
    bit            fix [2];
    logic          fix_we [2];
    logic [AW-1:0] fix_addr [2];
    logic [DW-1:0] fix_data [2];
    bit            ack_seen [2];

    // memory behind the DUT and the model's own view of it
    logic [DW-1:0] b_mem [32];
    logic [DW-1:0] m_mem [32];
    bit            rd_pend;
    int            rd_cnt;
    logic [AW-1:0] rd_addr;

    // transaction-level model: t counts cycles since the strobe cycle
    bit            m_act;
    int            m_own, m_t, m_last;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    int            m_cnt [2];
    logic [DW-1:0] m_rdata [2];

    // per-cycle snapshots
    bit            s_wr, s_rd, s_ga;
    logic [DW-1:0] s_rda;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_din;
    bit            st_ga;
    int            gq [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_own = 0; m_t = 0; m_last = 1; m_we = 0;
        m_addr = '0; m_din = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic check_model();
        int lat;
        if (!rst_n) model_reset();
        lat = m_we ? 1 : 1 + RD_LAT;
        chk("busy",        int'(busy),        int'(m_act));
        chk("gnt_a",       int'(gnt_a),       int'(m_act && m_own == 0));
        chk("gnt_b",       int'(gnt_b),       int'(m_act && m_own == 1));
        chk("mem_write",   int'(mem_write),   int'(m_act && m_t == 0 && m_we));
        chk("mem_read",    int'(mem_read),    int'(m_act && m_t == 0 && !m_we));
        chk("ack_a",       int'(ack_a),       int'(m_act && m_t == lat && m_own == 0));
        chk("ack_b",       int'(ack_b),       int'(m_act && m_t == lat && m_own == 1));
        chk("mem_addr",    int'(mem_addr),    int'(m_addr));
        chk("mem_data_in", int'(mem_data_in), int'(m_din));
        chk("rdata_a",     int'(rdata_a),     int'(m_rdata[0]));
        chk("rdata_b",     int'(rdata_b),     int'(m_rdata[1]));
        chk("cnt_a",       int'(cnt_a),       m_cnt[0]);
        chk("cnt_b",       int'(cnt_b),       m_cnt[1]);
    endtask

    task automatic advance_model();
        int lat, w;
        if (!rst_n) return;
        lat = m_we ? 1 : 1 + RD_LAT;
        if (m_act) begin
            if (m_t == lat) begin
                if (m_cnt[m_own] < CMAX) m_cnt[m_own]++;
                m_act = 0;
            end else begin
                if (m_t == 0 && m_we) m_mem[m_addr] = m_din;
                m_t++;
                if (m_t == lat && !m_we) m_rdata[m_own] = m_mem[m_addr];
            end
        end else if (req_v[0] || req_v[1]) begin
            if (req_v[0] && req_v[1]) w = (m_last == 1) ? 0 : 1;
            else                      w = req_v[0] ? 0 : 1;
            m_last = w; m_own = w; m_act = 1; m_t = 0;
            m_we = we_v[w]; m_addr = addr_v[w]; m_din = wdata_v[w];
        end
    endtask

    task automatic mem_model();
        if (!rst_n) rd_pend = 0;
        if (mem_write) b_mem[mem_addr] = mem_data_in;
        mem_data_out = DW'($urandom);
        if (rd_pend) begin
            if (rd_cnt == 1) begin
                mem_data_out = b_mem[rd_addr];
                rd_pend = 0;
            end else begin
                rd_cnt--;
            end
        end
        if (mem_read) begin
            rd_pend = 1; rd_cnt = RD_LAT; rd_addr = mem_addr;
        end
    endtask

    task automatic new_cmd(input int i);
        req_v[i] = 1'b1;
        if (fix[i]) begin
            we_v[i] = fix_we[i]; addr_v[i] = fix_addr[i]; wdata_v[i] = fix_data[i];
        end else begin
            we_v[i] = 1'($urandom_range(1)); addr_v[i] = AW'($urandom); wdata_v[i] = DW'($urandom);
        end
    endtask

    task automatic drive_agents();
        for (int i = 0; i < 2; i++) begin
            if (req_v[i] && ack_seen[i]) req_v[i] = 1'b0;
            if (!req_v[i] && int'($urandom_range(99)) < prob[i]) new_cmd(i);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_wr = mem_write; s_rd = mem_read; s_ga = gnt_a; s_rda = rdata_a;
        if (mem_write || mem_read) begin
            st_addr = mem_addr; st_din = mem_data_in; st_ga = gnt_a;
        end
        ack_seen[0] = ack_a; ack_seen[1] = ack_b;
        if (ack_a) gq.push_back(0);
        if (ack_b) gq.push_back(1);
        check_model();
        mem_model();
        advance_model();
        @(posedge clk);
        #1;
        drive_agents();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_until_ack(input int i, input int max, output int n,
                                 output int wr_p, output int rd_p);
        bit hit = 0;
        n = 0; wr_p = 0; rd_p = 0;
        while (!hit && n < max) begin
            tick();
            n++;
            wr_p += int'(s_wr);
            rd_p += int'(s_rd);
            hit = ack_seen[i];
        end
        chk("ack_reached", int'(hit), 1);
    endtask

    task automatic wait_grants(input int cnt, input int max);
        int n = 0;
        while (gq.size() < cnt && n < max) begin
            tick();
            n++;
        end
        chk("grants_reached", int'(gq.size() >= cnt), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        ticks(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, wp, rp, ga_cnt, a_wins;
        int g [4];
        logic [DW-1:0] old9, v9;

        for (int i = 0; i < 32; i++) begin
            b_mem[i] = DW'($urandom);
            m_mem[i] = b_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 0; we_v[i] = 0; addr_v[i] = '0; wdata_v[i] = '0;
            prob[i] = 0; fix[i] = 0; fix_we[i] = 0; fix_addr[i] = '0; fix_data[i] = '0;
            ack_seen[i] = 0;
        end
        rd_pend = 0; rd_cnt = 0; rd_addr = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_busy", int'(busy), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);

        // A writes 0xA5 to address 5
        req_v[0] = 1; we_v[0] = 1; addr_v[0] = 5'd5; wdata_v[0] = 8'hA5;
        run_until_ack(0, 20, n, wp, rp);
        chk("wr_latency", n - 1, 2);
        chk("wr_pulses", wp, 1);
        chk("wr_no_read", rp, 0);
        chk("wr_addr", int'(st_addr), 5);
        chk("wr_data", int'(st_din), 8'hA5);
        chk("wr_gnt_a", int'(st_ga), 1);
        tick();
        chk("cnt_a_one", int'(cnt_a), 1);
        chk("mem5", int'(b_mem[5]), 8'hA5);

        // A reads it back
        req_v[0] = 1; we_v[0] = 0; addr_v[0] = 5'd5;
        run_until_ack(0, 20, n, wp, rp);
        chk("rd_latency", n - 1, 2 + RD_LAT);
        chk("rd_pulses", rp, 1);
        chk("rd_no_write", wp, 0);
        chk("rd_data_at_ack", int'(s_rda), 8'hA5);
        ticks(4);
        chk("rd_data_held", int'(rdata_a), 8'hA5);

        // continuous contention: strict alternation starting with A
        do_reset();
        gq.delete();
        fix[0] = 1; fix_we[0] = 1; fix_addr[0] = 5'd0;  fix_data[0] = 8'h11;
        fix[1] = 1; fix_we[1] = 1; fix_addr[1] = 5'd31; fix_data[1] = 8'hEE;
        prob[0] = 100; prob[1] = 100;
        new_cmd(0); new_cmd(1);
        wait_grants(4, 40);
        for (int k = 0; k < 4; k++) g[k] = (k < gq.size()) ? gq[k] : -1;
        chk("order0", g[0], 0);
        chk("order1", g[1], 1);
        chk("order2", g[2], 0);
        chk("order3", g[3], 1);
        prob[0] = 0; prob[1] = 0;
        ticks(10);
        chk("mem0", int'(b_mem[0]), 8'h11);
        chk("mem31", int'(b_mem[31]), 8'hEE);

        // B alone three times, then a tie goes to A
        fix[0] = 0; fix[1] = 0;
        gq.delete();
        ga_cnt = 0;
        prob[1] = 100;
        n = 0;
        while (gq.size() < 3 && n < 60) begin
            tick();
            n++;
            ga_cnt += int'(s_ga);
        end
        prob[1] = 0;
        a_wins = 0;
        foreach (gq[k]) if (gq[k] == 0) a_wins++;
        chk("b_only_reached", int'(gq.size() >= 3), 1);
        chk("b_only_no_a", a_wins, 0);
        chk("b_only_no_gnt_a", ga_cnt, 0);
        ticks(10);
        gq.delete();
        new_cmd(0); new_cmd(1);
        wait_grants(1, 20);
        chk("tie_after_b", (gq.size() > 0) ? gq[0] : -1, 0);
        ticks(15);

        // reset while a read sits in WAIT
        req_v[0] = 1; we_v[0] = 0; addr_v[0] = 5'd7;
        ticks(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_ack_a", int'(ack_a), 0);
        chk("rst_ack_b", int'(ack_b), 0);
        chk("rst_rdata_a", int'(rdata_a), 0);
        chk("rst_rdata_b", int'(rdata_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt_a", int'(gnt_a), 0);
        ticks(2);
        rst_n = 1'b1;
        gq.delete();
        new_cmd(1);
        wait_grants(1, 20);
        chk("tie_after_reset", (gq.size() > 0) ? gq[0] : -1, 0);
        ticks(15);

        // reset during the ACCESS of a write must not reach memory
        old9 = b_mem[9];
        v9 = old9 ^ 8'h5A;
        req_v[0] = 1; we_v[0] = 1; addr_v[0] = 5'd9; wdata_v[0] = v9;
        tick();
        #2;
        rst_n = 1'b0;
        req_v[0] = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        chk("aborted_write", int'(b_mem[9]), int'(old9));

        // counter saturation
        do_reset();
        gq.delete();
        fix[0] = 1; fix_we[0] = 1; fix_addr[0] = 5'd3; fix_data[0] = 8'h3C;
        prob[0] = 100;
        wait_grants(20, 200);
        prob[0] = 0;
        ticks(6);
        chk("cnt_a_sat", int'(cnt_a), CMAX);
        chk("cnt_b_zero", int'(cnt_b), 0);

        // random traffic
        fix[0] = 0; fix[1] = 0;
        prob[0] = 40; prob[1] = 40;
        ticks(1500);
        prob[0] = 90; prob[1] = 90;
        ticks(500);
        prob[0] = 0; prob[1] = 0;
        ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
